control_unit: RTL and testbench

Multicycle control FSM that sequences the 16-bit processor datapath: register file, ALU, shifter, PC/source/destination/immediate/result registers, and the mux tree feeding them. It fetches each instruction, decodes opcode fields, drives every enable and select on the datapath, and holds the processor status flags (C, L, F, Z, N) captured from the ALU. It sits beside the datapath at the top level and is the only block that changes architectural state.

---
 rtl/control_unit.sv | 185 ++++++++++++++++++
 tb/tb_control_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multicycle FETCH/DECODE/EXEC/WB sequencer for the 16-bit datapath.
// Drives every datapath enable/select and owns the registered status flags.
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        C,
    input  logic        L,
    input  logic        F,
    input  logic        Z,
    input  logic        N,
    output logic        irEn,
    output logic        pcRegEn,
    output logic        srcRegEn,
    output logic        dstRegEn,
    output logic        immRegEn,
    output logic        resultRegEn,
    output logic        regFileEn,
    output logic        signEn,
    output logic        pcRegMuxEn,
    output logic [1:0]  mux4En,
    output logic        regImmMuxEn,
    output logic        shiftALUMuxEn,
    output logic [1:0]  regFileResultCont,
    output logic [3:0]  aluControl,
    output logic        memAddrSel,
    output logic        memWrite,
    output logic [4:0]  psr,
    output logic        illegal,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_PASSB = 4'b0101;

    // {valid, aluControl} for the code shared by R-type ext and immediate op.
    function automatic logic [4:0] alu_map(input logic [3:0] code);
        case (code)
            4'b0101: alu_map = {1'b1, ALU_ADD};
            4'b1001: alu_map = {1'b1, ALU_SUB};
            4'b0001: alu_map = {1'b1, ALU_AND};
            4'b0010: alu_map = {1'b1, ALU_OR};
            4'b0011: alu_map = {1'b1, ALU_XOR};
            4'b1101: alu_map = {1'b1, ALU_PASSB};
            default: alu_map = 5'b0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  psr_q, psr_d;
    logic [3:0]  op, ext, cond;
    logic [4:0]  alu_r, alu_i, flags;
    logic        taken;
    logic        unused_bits;

    assign op          = instr[15:12];
    assign cond        = instr[11:8];
    assign ext         = instr[7:4];
    assign unused_bits = ^instr[3:0];
    assign alu_r       = alu_map(ext);
    assign alu_i       = alu_map(op);
    assign flags       = {C, L, F, Z, N};
    assign taken       = (cond == 4'b0000) ?  psr_q[1] :
                         (cond == 4'b0001) ? !psr_q[1] :
                         (cond == 4'b1110);

    always_comb begin
        state_d           = state_q;
        psr_d             = psr_q;
        irEn              = 1'b0;
        pcRegEn           = 1'b0;
        srcRegEn          = 1'b0;
        dstRegEn          = 1'b0;
        immRegEn          = 1'b0;
        resultRegEn       = 1'b0;
        regFileEn         = 1'b0;
        signEn            = 1'b0;
        pcRegMuxEn        = 1'b0;
        mux4En            = 2'd0;
        regImmMuxEn       = 1'b0;
        shiftALUMuxEn     = 1'b0;
        regFileResultCont = 2'd0;
        aluControl        = ALU_ADD;
        memAddrSel        = 1'b0;
        memWrite          = 1'b0;
        illegal           = 1'b0;
        // Outputs are forced quiet while reset is held so nothing writes.
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    irEn    = 1'b1;
                    state_d = DECODE;
                end
                DECODE: begin
                    srcRegEn = 1'b1;
                    dstRegEn = 1'b1;
                    immRegEn = 1'b1;
                    mux4En   = 2'd2;
                    pcRegEn  = 1'b1;
                    state_d  = EXEC;
                end
                EXEC: begin
                    state_d = FETCH;
                    if (op == 4'b0000 && alu_r[4]) begin
                        pcRegMuxEn  = 1'b1;
                        aluControl  = alu_r[3:0];
                        resultRegEn = 1'b1;
                        if (alu_r[3:1] == 3'b000) psr_d = flags;
                        state_d     = WB;
                    end else if (op == 4'b0000 && ext == 4'b1011) begin
                        pcRegMuxEn = 1'b1;
                        aluControl = ALU_SUB;
                        psr_d      = flags;
                    end else if (alu_i[4]) begin
                        pcRegMuxEn  = 1'b1;
                        mux4En      = 2'd1;
                        signEn      = (op[3:2] != 2'b00);
                        aluControl  = alu_i[3:0];
                        resultRegEn = 1'b1;
                        if (alu_i[3:1] == 3'b000) psr_d = flags;
                        state_d     = WB;
                    end else if (op == 4'b1011) begin
                        pcRegMuxEn = 1'b1;
                        mux4En     = 2'd1;
                        signEn     = 1'b1;
                        aluControl = ALU_SUB;
                        psr_d      = flags;
                    end else if (op == 4'b1000 &&
                                 (ext == 4'b0100 || ext == 4'b0000 || ext == 4'b0001)) begin
                        regImmMuxEn   = (ext != 4'b0100);
                        signEn        = (ext != 4'b0100);
                        shiftALUMuxEn = 1'b1;
                        resultRegEn   = 1'b1;
                        state_d       = WB;
                    end else if (op == 4'b0100 && ext == 4'b0000) begin
                        memAddrSel        = 1'b1;
                        regFileResultCont = 2'd1;
                        regFileEn         = 1'b1;
                    end else if (op == 4'b0100 && ext == 4'b0100) begin
                        memAddrSel = 1'b1;
                        memWrite   = 1'b1;
                    end else if (op == 4'b1100) begin
                        if (taken) begin
                            mux4En  = 2'd1;
                            signEn  = 1'b1;
                            pcRegEn = 1'b1;
                        end
                    end else begin
                        illegal = 1'b1;
                    end
                end
                WB: begin
                    regFileEn = 1'b1;
                    state_d   = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            psr_q   <= 5'b0;
        end else begin
            state_q <= state_d;
            psr_q   <= psr_d;
        end
    end

    assign psr       = psr_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction table, reset corner cases,
// then random instructions checked cycle by cycle against a reference model.
module tb_control_unit;

    typedef struct packed {
        logic       ir, pc, src, dst, imm, res, rf, sign, pcmux;
        logic [1:0] m4;
        logic       rim, sam;
        logic [1:0] rfc;
        logic [3:0] alu;
        logic       mas, mw, ill;
    } ctl_t;

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  flags;
        int          cycles;
        logic [4:0]  psr_after;
        ctl_t        exec;
    } vec_t;

    logic        clk, reset;
    logic [15:0] instr;
    logic        C, L, F, Z, N;
    logic        irEn, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn, regFileEn;
    logic        signEn, pcRegMuxEn, regImmMuxEn, shiftALUMuxEn, memAddrSel, memWrite, illegal;
    logic [1:0]  mux4En, regFileResultCont, state_dbg;
    logic [3:0]  aluControl;
    logic [4:0]  psr;
    ctl_t        act;

    int tests = 0;
    int fails = 0;

    control_unit dut (
        .clk(clk), .reset(reset), .instr(instr),
        .C(C), .L(L), .F(F), .Z(Z), .N(N),
        .irEn(irEn), .pcRegEn(pcRegEn), .srcRegEn(srcRegEn), .dstRegEn(dstRegEn),
        .immRegEn(immRegEn), .resultRegEn(resultRegEn), .regFileEn(regFileEn),
        .signEn(signEn), .pcRegMuxEn(pcRegMuxEn), .mux4En(mux4En),
        .regImmMuxEn(regImmMuxEn), .shiftALUMuxEn(shiftALUMuxEn),
        .regFileResultCont(regFileResultCont), .aluControl(aluControl),
        .memAddrSel(memAddrSel), .memWrite(memWrite), .psr(psr),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    assign act = {irEn, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn, regFileEn,
                  signEn, pcRegMuxEn, mux4En, regImmMuxEn, shiftALUMuxEn,
                  regFileResultCont, aluControl, memAddrSel, memWrite, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic ctl_t mk(input int alu, input int m4, input bit pcmux, input bit sign,
                                input bit res, input bit rf, input bit pc, input bit rim,
                                input bit sam, input int rfc, input bit mas, input bit mw,
                                input bit ill);
        ctl_t c;
        c       = '0;
        c.alu   = alu[3:0];
        c.m4    = m4[1:0];
        c.pcmux = pcmux;
        c.sign  = sign;
        c.res   = res;
        c.rf    = rf;
        c.pc    = pc;
        c.rim   = rim;
        c.sam   = sam;
        c.rfc   = rfc[1:0];
        c.mas   = mas;
        c.mw    = mw;
        c.ill   = ill;
        return c;
    endfunction

    // ADD=0, SUB=1, AND=2, OR=3, XOR=4, MOV=5; -1 if the code names no ALU op.
    function automatic int alu_num(input logic [3:0] code);
        case (code)
            4'h5: return 0;
            4'h9: return 1;
            4'h1: return 2;
            4'h2: return 3;
            4'h3: return 4;
            4'hD: return 5;
            default: return -1;
        endcase
    endfunction

    // Reference: what EXEC must drive, how long the instruction takes, and
    // whether it captures flags, derived from the instruction-set rules.
    function automatic void model(input logic [15:0] ins, input logic [4:0] ps,
                                  output ctl_t c, output int cyc, output logic upd);
        logic [3:0] op, ext, cond;
        int ar, ai;
        logic take;
        op   = ins[15:12];
        cond = ins[11:8];
        ext  = ins[7:4];
        ar   = alu_num(ext);
        ai   = alu_num(op);
        c    = '0;
        cyc  = 3;
        upd  = 1'b0;
        if (op == 4'h0 && ar >= 0) begin
            c = mk(ar, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            cyc = 4;
            upd = (ar <= 1);
        end else if (op == 4'h0 && ext == 4'hB) begin
            c = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            upd = 1'b1;
        end else if (ai >= 0) begin
            c = mk(ai, 1, 1, !(ai inside {2, 3, 4}), 1, 0, 0, 0, 0, 0, 0, 0, 0);
            cyc = 4;
            upd = (ai <= 1);
        end else if (op == 4'hB) begin
            c = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            upd = 1'b1;
        end else if (op == 4'h8 && ext inside {4'h0, 4'h1, 4'h4}) begin
            c = mk(0, 0, 0, ext != 4'h4, 1, 0, 0, ext != 4'h4, 1, 0, 0, 0, 0);
            cyc = 4;
        end else if (op == 4'h4 && ext == 4'h0) begin
            c = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        end else if (op == 4'h4 && ext == 4'h4) begin
            c = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        end else if (op == 4'hC) begin
            take = (cond == 4'h0) ? ps[1] : (cond == 4'h1) ? !ps[1] : (cond == 4'hE);
            if (take) c = mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        end else begin
            c.ill = 1'b1;
        end
    endfunction

    ctl_t fetch_c, decode_c, wb_c;

    // Entered just after a falling edge with the DUT in FETCH; leaves it the same way.
    task automatic run_instr(input logic [15:0] ins, input logic [4:0] fl, input ctl_t ex,
                             input int cyc, input logic [4:0] ps, input string nm);
        instr = ins;
        {C, L, F, Z, N} = fl;
        #1;
        chk({nm, " fetch state"}, {30'b0, state_dbg}, 0);
        chk({nm, " fetch ctl"}, {10'b0, act}, {10'b0, fetch_c});
        @(negedge clk);
        chk({nm, " decode state"}, {30'b0, state_dbg}, 1);
        chk({nm, " decode ctl"}, {10'b0, act}, {10'b0, decode_c});
        @(negedge clk);
        chk({nm, " exec state"}, {30'b0, state_dbg}, 2);
        chk({nm, " exec ctl"}, {10'b0, act}, {10'b0, ex});
        if (cyc == 4) begin
            @(negedge clk);
            chk({nm, " wb state"}, {30'b0, state_dbg}, 3);
            chk({nm, " wb ctl"}, {10'b0, act}, {10'b0, wb_c});
        end
        @(negedge clk);
        chk({nm, " end state"}, {30'b0, state_dbg}, 0);
        chk({nm, " psr"}, {27'b0, psr}, {27'b0, ps});
    endtask

    vec_t vecs[24];
    logic [3:0] ops[12] = '{4'h0, 4'h5, 4'h9, 4'hB, 4'hD, 4'h1, 4'h2, 4'h3, 4'h8, 4'h4, 4'hC, 4'hF};
    logic [3:0] exts[10] = '{4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hB, 4'hD, 4'h4, 4'h0, 4'h7};
    logic [3:0] conds[4] = '{4'h0, 4'h1, 4'hE, 4'h6};

    initial begin
        ctl_t       ec;
        int         cyc;
        logic       upd;
        logic [4:0] m_psr, fl;
        logic [15:0] ins;

        fetch_c  = '0; fetch_c.ir = 1'b1;
        decode_c = '0; decode_c.src = 1'b1; decode_c.dst = 1'b1; decode_c.imm = 1'b1;
        decode_c.pc = 1'b1; decode_c.m4 = 2'd2;
        wb_c     = '0; wb_c.rf = 1'b1;

        //              instr     flags     cyc psr_after exec: alu m4 pm sg rs rf pc ri sa rc ma mw il
        vecs[0]  = '{16'h0152, 5'b10101, 4, 5'b10101, mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{16'h0312, 5'b11111, 4, 5'b10101, mk(2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{16'h0391, 5'b00010, 4, 5'b00010, mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{16'h01B2, 5'b01000, 3, 5'b01000, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{16'hB305, 5'b00010, 3, 5'b00010, mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{16'hC0FE, 5'b11101, 3, 5'b00010, mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[6]  = '{16'hC1FE, 5'b00000, 3, 5'b00010, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{16'hB305, 5'b00000, 3, 5'b00000, mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[8]  = '{16'hC0FE, 5'b00010, 3, 5'b00000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{16'hC1FE, 5'b00010, 3, 5'b00000, mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{16'hCE05, 5'b00000, 3, 5'b00000, mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[11] = '{16'hC705, 5'b11111, 3, 5'b00000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[12] = '{16'h2312, 5'b11111, 4, 5'b00000, mk(3, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[13] = '{16'h5305, 5'b11001, 4, 5'b11001, mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[14] = '{16'h9305, 5'b00110, 4, 5'b00110, mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[15] = '{16'h8403, 5'b00001, 4, 5'b00110, mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0)};
        vecs[16] = '{16'h8442, 5'b11111, 4, 5'b00110, mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0)};
        vecs[17] = '{16'h4102, 5'b11111, 3, 5'b00110, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0)};
        vecs[18] = '{16'h4142, 5'b11111, 3, 5'b00110, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0)};
        vecs[19] = '{16'hF000, 5'b11111, 3, 5'b00110, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vecs[20] = '{16'h03D2, 5'b00001, 4, 5'b00110, mk(5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[21] = '{16'h3312, 5'b10000, 4, 5'b00110, mk(4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[22] = '{16'h0102, 5'b11111, 3, 5'b00110, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vecs[23] = '{16'hD312, 5'b11111, 4, 5'b00110, mk(5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)};

        reset = 1'b1;
        instr = 16'h0152;
        {C, L, F, Z, N} = 5'b11111;
        @(negedge clk);
        @(negedge clk);
        chk("reset ctl", {10'b0, act}, 32'd0);
        chk("reset state", {30'b0, state_dbg}, 0);
        chk("reset psr", {27'b0, psr}, 0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++)
            run_instr(vecs[i].instr, vecs[i].flags, vecs[i].exec, vecs[i].cycles,
                      vecs[i].psr_after, $sformatf("vec%0d", i));

        // Reset landing in WB of an ADD must kill the pending register write.
        instr = 16'h0152;
        {C, L, F, Z, N} = 5'b11111;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("wb pre-reset rf", {31'b0, regFileEn}, 1);
        chk("wb pre-reset psr", {27'b0, psr}, 32'h1F);
        #1 reset = 1'b1;
        #1;
        chk("mid reset rf", {31'b0, regFileEn}, 0);
        chk("mid reset ctl", {10'b0, act}, 32'd0);
        chk("mid reset state", {30'b0, state_dbg}, 0);
        chk("mid reset psr", {27'b0, psr}, 0);
        @(negedge clk);
        chk("held reset state", {30'b0, state_dbg}, 0);
        reset = 1'b0;

        m_psr = 5'b0;
        for (int i = 0; i < 300; i++) begin
            ins = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) != 0) begin
                ins[15:12] = ops[$urandom_range(0, 11)];
                ins[7:4]   = exts[$urandom_range(0, 9)];
                if (ins[15:12] == 4'hC) ins[11:8] = conds[$urandom_range(0, 3)];
            end
            fl = 5'($urandom_range(0, 31));
            model(ins, m_psr, ec, cyc, upd);
            if (upd) m_psr = fl;
            run_instr(ins, fl, ec, cyc, m_psr, $sformatf("rnd%0d_%h", i, ins));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
